// File: rtl/alarm_input_conditioner.sv
// Four-switch alarm front end: 2-flop sync, per-switch debounce, one-hot decode.
// Define ALARM_LATCH_EN to latch the first alarm until acknowledged with all switches off.
module alarm_input_conditioner #(
    parameter int unsigned DB_LIMIT = 1000000,
    parameter int unsigned DB_CNT_W = 20
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       switch_0,
    input  logic       switch_1,
    input  logic       switch_2,
    input  logic       switch_3,
    input  logic       ack,
    output logic [3:0] alarm_code,
    output logic       alarm_new,
    output logic       alarm_invalid
);

    localparam logic [DB_CNT_W-1:0] LimitM1 = DB_CNT_W'(DB_LIMIT - 1);

    logic [3:0]          raw;
    logic [3:0]          sync1_q, sync2_q;
    logic [3:0]          stable_q, stable_d;
    logic [DB_CNT_W-1:0] cnt_q [4];
    logic [DB_CNT_W-1:0] cnt_d [4];
    logic [2:0]          ones;
    logic [3:0]          cand;
    logic                invalid_d, invalid_q;
    logic [3:0]          code_d, code_q;
    logic                new_d, new_q;

    assign raw = {switch_3, switch_2, switch_1, switch_0};

    // Counter runs only while the synchronized level disagrees with the stable bit.
    always_comb begin
        stable_d = stable_q;
        for (int i = 0; i < 4; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != stable_q[i]) begin
                if (cnt_q[i] == LimitM1) begin
                    stable_d[i] = ~stable_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + DB_CNT_W'(1);
                end
            end
        end
    end

    always_comb begin
        ones = 3'd0;
        for (int i = 0; i < 4; i++) begin
            ones = ones + {2'b00, stable_q[i]};
        end
        cand      = (ones == 3'd1) ? stable_q : 4'b0000;
        invalid_d = (ones >= 3'd2);
    end

`ifdef ALARM_LATCH_EN
    typedef enum logic {StIdle, StLatched} state_e;

    state_e state_q, state_d;

    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        unique case (state_q)
            StIdle: begin
                if (cand != 4'b0000) begin
                    state_d = StLatched;
                    code_d  = cand;
                end
            end
            StLatched: begin
                // Release only once the operator acks with every switch settled off.
                if (ack && (stable_q == 4'b0000)) begin
                    state_d = StIdle;
                    code_d  = 4'b0000;
                end
            end
            default: begin
                state_d = StIdle;
                code_d  = 4'b0000;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end
`else
    logic unused_ack;
    assign unused_ack = ack;

    always_comb begin
        code_d = cand;
    end
`endif

    assign new_d = (code_d != 4'b0000) && (code_d != code_q);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            stable_q  <= '0;
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= '0;
            end
            code_q    <= '0;
            new_q     <= 1'b0;
            invalid_q <= 1'b0;
        end else begin
            sync1_q   <= raw;
            sync2_q   <= sync1_q;
            stable_q  <= stable_d;
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            code_q    <= code_d;
            new_q     <= new_d;
            invalid_q <= invalid_d;
        end
    end

    assign alarm_code    = code_q;
    assign alarm_new     = new_q;
    assign alarm_invalid = invalid_q;

endmodule
